ex_wb_stage: RTL and testbench

EX_WB_STAGE -- requirements
Module: ex_wb_stage

---
 rtl/mips4_pkg.sv | 35 +++
 rtl/reg_file_8x8.sv | 53 +++++
 rtl/ex_wb_stage.sv | 135 +++++++++++++
 tb/tb_ex_wb_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips4_pkg.sv
// mips4_pkg -- shared definitions for the 4-stage teaching MIPS datapath.
//
// Holds the data and register-address widths used by both the ID/EX
// register and the EX/WB stage, plus the EX/WB pipeline record and a small
// add-with-carry helper.
//
// Ports: none (package).
package mips4_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Operand B selection for the ALU.
  typedef enum logic {
    SRC_REG = 1'b0,
    SRC_IMM = 1'b1
  } alu_src_e;

  // Contents of the EX/WB pipeline register.
  typedef struct packed {
    data_t     data;
    reg_addr_t rd;
    logic      regwrite;
  } ex_wb_t;

  // 9-bit sum so the carry out of the 8-bit add is bit DATA_W.
  function automatic logic [DATA_W:0] add_with_carry(input data_t a, input data_t b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/reg_file_8x8.sv
// reg_file_8x8 -- 8 x 8-bit architectural register file.
//
// Two combinational operand read ports, one combinational debug read port
// and one synchronous write port. All entries (including R0) are writable.
// Every entry clears immediately on an asynchronous reset.
//
// Ports:
//   clock        input   rising-edge write clock
//   reset        input   asynchronous active-high clear
//   rs_addr_i    input   operand B read index
//   rs_data_o    output  R[rs_addr_i]
//   rd_addr_i    input   operand A read index
//   rd_data_o    output  R[rd_addr_i]
//   dbg_addr_i   input   debug read index
//   dbg_data_o   output  R[dbg_addr_i]
//   we_i         input   write enable
//   waddr_i      input   write index
//   wdata_i      input   write data
module reg_file_8x8
  import mips4_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  reg_addr_t rs_addr_i,
  output data_t     rs_data_o,
  input  reg_addr_t rd_addr_i,
  output data_t     rd_data_o,
  input  reg_addr_t dbg_addr_i,
  output data_t     dbg_data_o,
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  data_t     wdata_i
);

  data_t regs_q [NUM_REGS];

  // Storage: cleared asynchronously, otherwise one write per rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports see the stored value only; any bypassing happens outside.
  assign rs_data_o  = regs_q[rs_addr_i];
  assign rd_data_o  = regs_q[rd_addr_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/ex_wb_stage.sv
// ex_wb_stage -- execute stage, EX/WB pipeline register and register file.
//
// Executes either a load-immediate or a register add (Rd <= Rd + Rs),
// registers the result into EX/WB, and writes it back into the register
// file one cycle later. Zero/carry flags track the last instruction that
// writes a register.
//
// Configuration macro:
//   EX_WB_FORWARD_EN  when defined, operands are bypassed from the EX/WB
//                     register so back-to-back dependent instructions see
//                     the newest value. When undefined, operands come
//                     straight from the register file.
//
// Ports:
//   clock           input   rising-edge clock
//   reset           input   asynchronous active-high reset
//   id_ex_rddata    input   immediate operand
//   id_ex_rs        input   source register index (operand B)
//   id_ex_rd        input   destination index, also operand A
//   id_ex_regwrite  input   instruction writes Rd
//   id_ex_alusrc    input   1 = load immediate, 0 = register add
//   dbg_addr        input   debug read index
//   wb_data         output  registered result
//   wb_rd           output  registered destination
//   wb_regwrite     output  registered write enable
//   zero_flag       output  last written result was zero
//   carry_flag      output  carry out of the last written add
//   dbg_data        output  architectural R[dbg_addr], no bypass
module ex_wb_stage
  import mips4_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     id_ex_rddata,
  input  logic [REG_ADDR_W-1:0] id_ex_rs,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_regwrite,
  input  logic                  id_ex_alusrc,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_regwrite,
  output logic                  zero_flag,
  output logic                  carry_flag,
  output logic [DATA_W-1:0]     dbg_data
);

  ex_wb_t ex_wb_q, ex_wb_d;
  logic   zero_q, zero_d;
  logic   carry_q, carry_d;

  data_t  rf_rd_data;
  data_t  rf_rs_data;
  data_t  op_a;
  data_t  op_b;
  data_t  result;
  logic   carry;
  logic [DATA_W:0] sum;

  // The write port is driven from EX/WB, so an instruction becomes
  // architectural two edges after issue. During reset the EX/WB record is
  // held cleared, which also suppresses any write on the release edge.
  reg_file_8x8 u_reg_file (
    .clock      (clock),
    .reset      (reset),
    .rs_addr_i  (id_ex_rs),
    .rs_data_o  (rf_rs_data),
    .rd_addr_i  (id_ex_rd),
    .rd_data_o  (rf_rd_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data),
    .we_i       (ex_wb_q.regwrite),
    .waddr_i    (ex_wb_q.rd),
    .wdata_i    (ex_wb_q.data)
  );

  // Operand selection. Each operand is bypassed independently, so an
  // instruction with rs == rd == wb_rd gets the fresh value on both sides.
  always_comb begin
`ifdef EX_WB_FORWARD_EN
    op_a = (ex_wb_q.regwrite && (ex_wb_q.rd == id_ex_rd)) ? ex_wb_q.data : rf_rd_data;
    op_b = (ex_wb_q.regwrite && (ex_wb_q.rd == id_ex_rs)) ? ex_wb_q.data : rf_rs_data;
`else
    op_a = rf_rd_data;
    op_b = rf_rs_data;
`endif
  end

  // ALU: the add is always evaluated; the immediate path just overrides it
  // and reports no carry.
  always_comb begin
    sum = add_with_carry(op_a, op_b);
    if (alu_src_e'(id_ex_alusrc) == SRC_IMM) begin
      result = id_ex_rddata;
      carry  = 1'b0;
    end else begin
      result = sum[DATA_W-1:0];
      carry  = sum[DATA_W];
    end
  end

  // Next-state: EX/WB captures every cycle, flags only move on
  // instructions that actually write a register.
  always_comb begin
    ex_wb_d.data     = result;
    ex_wb_d.rd       = id_ex_rd;
    ex_wb_d.regwrite = id_ex_regwrite;
    zero_d           = zero_q;
    carry_d          = carry_q;
    if (id_ex_regwrite) begin
      zero_d  = (result == '0);
      carry_d = carry;
    end
  end

  // EX/WB pipeline register and flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_wb_q <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      ex_wb_q <= ex_wb_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign wb_data     = ex_wb_q.data;
  assign wb_rd       = ex_wb_q.rd;
  assign wb_regwrite = ex_wb_q.regwrite;
  assign zero_flag   = zero_q;
  assign carry_flag  = carry_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// tb_ex_wb_stage -- self-checking bench for ex_wb_stage.
//
// The reference model keeps the architectural register array, one pending
// write-back and the two flags, and advances them one instruction per clock.
// Build with EX_WB_FORWARD_EN defined to check the bypassed variant.
module tb_ex_wb_stage;

  logic       clock;
  logic       reset;
  logic [7:0] id_ex_rddata;
  logic [2:0] id_ex_rs;
  logic [2:0] id_ex_rd;
  logic       id_ex_regwrite;
  logic       id_ex_alusrc;
  logic [2:0] dbg_addr;
  logic [7:0] wb_data;
  logic [2:0] wb_rd;
  logic       wb_regwrite;
  logic       zero_flag;
  logic       carry_flag;
  logic [7:0] dbg_data;

`ifdef EX_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int errorCount = 0;
  int checkCount = 0;

  // Reference model state.
  logic [7:0] mRegs [8];
  logic [7:0] mPendData;
  logic [2:0] mPendRd;
  logic       mPendWe;
  logic       mZero;
  logic       mCarry;

  ex_wb_stage dut (
    .clock          (clock),
    .reset          (reset),
    .id_ex_rddata   (id_ex_rddata),
    .id_ex_rs       (id_ex_rs),
    .id_ex_rd       (id_ex_rd),
    .id_ex_regwrite (id_ex_regwrite),
    .id_ex_alusrc   (id_ex_alusrc),
    .dbg_addr       (dbg_addr),
    .wb_data        (wb_data),
    .wb_rd          (wb_rd),
    .wb_regwrite    (wb_regwrite),
    .zero_flag      (zero_flag),
    .carry_flag     (carry_flag),
    .dbg_data       (dbg_data)
  );

  // 10-unit clock period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mRegs[i] = 8'h00;
    mPendData = 8'h00;
    mPendRd   = 3'd0;
    mPendWe   = 1'b0;
    mZero     = 1'b0;
    mCarry    = 1'b0;
  endtask

  // Drive one instruction, let one rising edge pass, advance the model and
  // return at the following falling edge.
  task automatic applyStimulus(input logic alusrc, input logic rw, input logic [2:0] rd,
                               input logic [2:0] rs, input logic [7:0] imm);
    logic [7:0] a, b, res;
    logic       cy;
    int         total;
    id_ex_alusrc   = alusrc;
    id_ex_regwrite = rw;
    id_ex_rd       = rd;
    id_ex_rs       = rs;
    id_ex_rddata   = imm;
    // An operand sees the not-yet-written result only when bypassing exists.
    a = (FWD && mPendWe && mPendRd == rd) ? mPendData : mRegs[rd];
    b = (FWD && mPendWe && mPendRd == rs) ? mPendData : mRegs[rs];
    if (alusrc) begin
      res = imm;
      cy  = 1'b0;
    end else begin
      total = int'(a) + int'(b);
      res   = total[7:0];
      cy    = (total > 255);
    end
    @(posedge clock);
    if (mPendWe) mRegs[mPendRd] = mPendData;
    mPendData = res;
    mPendRd   = rd;
    mPendWe   = rw;
    if (rw) begin
      mZero  = (res == 8'h00);
      mCarry = cy;
    end
    @(negedge clock);
  endtask

  task automatic peekReg(input logic [2:0] idx);
    dbg_addr = idx;
    #1;
  endtask

  // Compare every output against the model, plus one random debug read.
  task automatic checkModel();
    logic [2:0] idx;
    checkOutput("wb_data", wb_data, mPendData);
    checkOutput("wb_rd", {5'd0, wb_rd}, {5'd0, mPendRd});
    checkOutput("wb_regwrite", {7'd0, wb_regwrite}, {7'd0, mPendWe});
    checkOutput("zero_flag", {7'd0, zero_flag}, {7'd0, mZero});
    checkOutput("carry_flag", {7'd0, carry_flag}, {7'd0, mCarry});
    idx = 3'($urandom_range(0, 7));
    peekReg(idx);
    checkOutput("dbg_data", dbg_data, mRegs[idx]);
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 8'h00);
  endtask

  initial begin
    reset          = 1'b1;
    id_ex_rddata   = 8'h00;
    id_ex_rs       = 3'd0;
    id_ex_rd       = 3'd0;
    id_ex_regwrite = 1'b0;
    id_ex_alusrc   = 1'b0;
    dbg_addr       = 3'd0;
    modelReset();
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Put some state in the pipeline so the reset has something to clear.
    applyStimulus(1'b1, 1'b1, 3'd6, 3'd0, 8'h99);
    applyStimulus(1'b1, 1'b1, 3'd7, 3'd0, 8'h00);
    checkModel();

    // Mid-cycle asynchronous reset: everything reads zero before any edge.
    #2 reset = 1'b1;
    #1;
    checkOutput("rst wb_data", wb_data, 8'h00);
    checkOutput("rst wb_rd", {5'd0, wb_rd}, 8'h00);
    checkOutput("rst wb_regwrite", {7'd0, wb_regwrite}, 8'h00);
    checkOutput("rst zero_flag", {7'd0, zero_flag}, 8'h00);
    checkOutput("rst carry_flag", {7'd0, carry_flag}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #0.2;
      checkOutput($sformatf("rst R%0d", i), dbg_data, 8'h00);
    end
    modelReset();
    @(negedge clock);
    reset = 1'b0;

    // Load immediate R3 = 0x2A; first instruction after reset.
    applyStimulus(1'b1, 1'b1, 3'd3, 3'd0, 8'h2A);
    checkOutput("ldi wb_data", wb_data, 8'h2A);
    checkOutput("ldi zero", {7'd0, zero_flag}, 8'h00);
    checkOutput("ldi carry", {7'd0, carry_flag}, 8'h00);
    idle();
    peekReg(3'd3);
    checkOutput("ldi R3", dbg_data, 8'h2A);

    // Back-to-back dependency on both operands.
    applyStimulus(1'b1, 1'b1, 3'd1, 3'd0, 8'h05);
    applyStimulus(1'b0, 1'b1, 3'd1, 3'd1, 8'h00);
    checkOutput("fwd add", wb_data, FWD ? 8'h0A : 8'h00);
    checkModel();
    idle();

    // 0xFF + 0x01 wraps silently with carry and zero set.
    applyStimulus(1'b1, 1'b1, 3'd2, 3'd0, 8'hFF);
    applyStimulus(1'b1, 1'b1, 3'd4, 3'd0, 8'h01);
    idle();
    applyStimulus(1'b0, 1'b1, 3'd2, 3'd4, 8'h00);
    checkOutput("wrap wb_data", wb_data, 8'h00);
    checkOutput("wrap carry", {7'd0, carry_flag}, 8'h01);
    checkOutput("wrap zero", {7'd0, zero_flag}, 8'h01);
    idle();
    peekReg(3'd2);
    checkOutput("wrap R2", dbg_data, 8'h00);

    // Add without write-back: result visible, file and flags untouched.
    applyStimulus(1'b0, 1'b0, 3'd3, 3'd3, 8'h00);
    checkOutput("norw wb_data", wb_data, 8'h54);
    checkOutput("norw wb_regwrite", {7'd0, wb_regwrite}, 8'h00);
    checkOutput("norw carry held", {7'd0, carry_flag}, 8'h01);
    checkOutput("norw zero held", {7'd0, zero_flag}, 8'h01);
    idle();
    peekReg(3'd3);
    checkOutput("norw R3", dbg_data, 8'h2A);
    checkModel();

    // Reset while a load to R5 is still in EX/WB.
    applyStimulus(1'b1, 1'b1, 3'd5, 3'd0, 8'h77);
    #1 reset = 1'b1;
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    idle();
    idle();
    peekReg(3'd5);
    checkOutput("inflight R5", dbg_data, 8'h00);
    checkModel();

    // Random instruction stream, biased toward a few registers so
    // dependencies and write-after-write happen often.
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 3) != 0),
                    3'($urandom_range(0, 3)),
                    3'($urandom_range(0, 3)),
                    8'($urandom));
      checkModel();
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
